// File: rtl/wallace_csa_reduce_pkg.sv
// +--------------------------------------------------------------------------+
// | Module  : wallace_pkg                                                    |
// | Brief   : Shared widths, row-count table and 3:2 compressor function for |
// |           the Wallace-tree reduction front end.                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package wallace_pkg;

    localparam int N_W        = 32;
    localparam int P_W        = 64;
    localparam int NUM_LAYERS = 8;

    // Unsigned row count entering each layer; the signed build starts at 33
    // and joins this sequence after the first layer.
    localparam int ROWS [0:NUM_LAYERS] = '{32, 22, 15, 10, 7, 5, 4, 3, 2};

    typedef struct packed {
        logic [P_W-1:0] s;
        logic [P_W-1:0] c;
    } csa_out_t;

    // Carry is returned already shifted to its weight; bit P_W-1's carry drops.
    function automatic csa_out_t csa3(input logic [P_W-1:0] x,
                                      input logic [P_W-1:0] y,
                                      input logic [P_W-1:0] z);
        csa_out_t res;
        res.s = x ^ y ^ z;
        res.c = ((x & y) | (x & z) | (y & z)) << 1;
        return res;
    endfunction

    function automatic int rows_after(input int start, input int layers);
        int r;
        r = start;
        for (int l = 0; l < layers; l++) begin
            r = (r / 3) * 2 + (r % 3);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wallace_csa_reduce_if.sv
// +--------------------------------------------------------------------------+
// | Module  : wallace_csa_reduce_if                                          |
// | Brief   : Operand / result handshake bundle of the CSA reduction tree.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface wallace_csa_reduce_if
    import wallace_pkg::*;
#(
    parameter int N = N_W
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] sum_vec;
    logic [2*N-1:0] carry_vec;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum_vec, carry_vec
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum_vec, carry_vec
    );

endinterface

`default_nettype wire

// File: rtl/wallace_csa_reduce_csa_3to2.sv
// +--------------------------------------------------------------------------+
// | Module  : csa_3to2                                                       |
// | Brief   : One full-width 3:2 carry-save compressor.                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module csa_3to2
    import wallace_pkg::*;
(
    input  wire logic [P_W-1:0] i_x,
    input  wire logic [P_W-1:0] i_y,
    input  wire logic [P_W-1:0] i_z,
    output logic      [P_W-1:0] o_s,
    output logic      [P_W-1:0] o_c
);

    csa_out_t w_res;

    assign w_res = csa3(i_x, i_y, i_z);
    assign o_s   = w_res.s;
    assign o_c   = w_res.c;

endmodule

`default_nettype wire

// File: rtl/wallace_csa_reduce.sv
// +--------------------------------------------------------------------------+
// | Module  : wallace_csa_reduce                                             |
// | Brief   : Pipelined Wallace-tree partial-product reduction to two 2N-bit |
// |           vectors; WALLACE_SIGNED_EN selects Baugh-Wooley signed mode.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module wallace_csa_reduce
    import wallace_pkg::*;
#(
    parameter int N   = N_W,
    parameter int LPS = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    wallace_csa_reduce_if.slave bus
);

`ifdef WALLACE_SIGNED_EN
    localparam int R0 = N + 1;
    localparam logic [P_W-1:0] BW_CONST = (P_W'(1) << N) | (P_W'(1) << (P_W - 1));
`else
    localparam int R0 = N;
`endif
    localparam int NSTG = NUM_LAYERS / LPS;

    logic           adv;
    logic [N-1:0]   a_q;
    logic [N-1:0]   a_d;
    logic [N-1:0]   b_q;
    logic [N-1:0]   b_d;
    logic [NSTG:0]  vld_q;
    logic [NSTG:0]  vld_d;
    logic [P_W-1:0] pp [R0];

    // One global stall: the whole pipe moves or the whole pipe holds.
    assign adv           = !vld_q[NSTG] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[NSTG];

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        vld_d = vld_q;
        if (adv) begin
            a_d   = bus.a;
            b_d   = bus.b;
            vld_d = {vld_q[NSTG-1:0], bus.in_valid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            vld_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            vld_q <= vld_d;
        end
    end

    always_comb begin : p_pp
        logic [P_W-1:0] row;
        row = '0;
        for (int r = 0; r < R0; r++) begin
            pp[r] = '0;
        end
        for (int i = 0; i < N; i++) begin
            row = '0;
            for (int j = 0; j < N; j++) begin
                row[j] = a_q[j] & b_q[i];
            end
`ifdef WALLACE_SIGNED_EN
            // Sign-weighted terms are complemented; BW_CONST restores the bias.
            if (i < N - 1) begin
                row[N-1] = ~(a_q[N-1] & b_q[i]);
            end else begin
                for (int j = 0; j < N - 1; j++) begin
                    row[j] = ~(a_q[j] & b_q[N-1]);
                end
            end
`endif
            pp[i] = row << i;
        end
`ifdef WALLACE_SIGNED_EN
        pp[N] = BW_CONST;
`endif
    end

    for (genvar s = 1; s <= NSTG; s++) begin : g_stage
        localparam int RS = rows_after(R0, s * LPS);

        logic [P_W-1:0] row_q [RS];
        logic [P_W-1:0] row_d [RS];

        for (genvar k = 0; k < LPS; k++) begin : g_layer
            localparam int L    = (s - 1) * LPS + k;
            localparam int RIN  = rows_after(R0, L);
            localparam int ROUT = rows_after(R0, L + 1);
            localparam int NG   = RIN / 3;

            logic [P_W-1:0] rin  [RIN];
            logic [P_W-1:0] rout [ROUT];

            for (genvar r = 0; r < RIN; r++) begin : g_src
                if (k > 0) begin : g_from_layer
                    assign rin[r] = g_layer[k-1].rout[r];
                end else if (s > 1) begin : g_from_stage
                    assign rin[r] = g_stage[s-1].row_q[r];
                end else begin : g_from_pp
                    assign rin[r] = pp[r];
                end
            end

            for (genvar g = 0; g < NG; g++) begin : g_csa
                csa_3to2 u_csa (
                    .i_x (rin[3*g]),
                    .i_y (rin[3*g+1]),
                    .i_z (rin[3*g+2]),
                    .o_s (rout[2*g]),
                    .o_c (rout[2*g+1])
                );
            end

            // Rows left over from the last full group of three pass straight on.
            for (genvar r = 3 * NG; r < RIN; r++) begin : g_pass
                assign rout[r-NG] = rin[r];
            end
        end

        always_comb begin
            for (int r = 0; r < RS; r++) begin
                row_d[r] = adv ? g_layer[LPS-1].rout[r] : row_q[r];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int r = 0; r < RS; r++) begin
                    row_q[r] <= '0;
                end
            end else begin
                for (int r = 0; r < RS; r++) begin
                    row_q[r] <= row_d[r];
                end
            end
        end
    end

    assign bus.sum_vec   = g_stage[NSTG].row_q[0];
    assign bus.carry_vec = g_stage[NSTG].row_q[1];

endmodule

`default_nettype wire
